argmax_stream: RTL
==================

# argmax_stream

Streaming top-2 argmax engine for the classifier output stage. It consumes one score per cycle from the final fully-connected layer and tracks the best and second-best scores of each frame of `NUM_CLASS` scores. One cycle after the last score it emits the winning class index, the winning score and the best-minus-second margin. It accepts back-to-back frames with no idle cycles. A synchronous abort is provided.

## Interface
- `NUM_CLASS`, default 10: scores per frame, minimum 1.
- `DATA_W`, default 12: score width.
- `SIGNED`, default 1: 1 compares two's-complement scores; 0 compares unsigned scores.
- `IDX_W`, default `$clog2(NUM_CLASS)` (minimum 1): class index width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `clear` input 1: synchronous abort of the frame in progress.
- `valid_in` input 1: `data_in` carries a score this cycle.
- `data_in` input DATA_W: score. Interpretation is set by `SIGNED`.
- `decision` output IDX_W: index of the best score.
- `max_out` output DATA_W: best score.
- `margin` output DATA_W+1: best minus second-best, unsigned, never negative.
- `valid_out` output 1: one-cycle pulse marking a new result.

## Operation
- Element counter `cnt` (0..NUM_CLASS-1) increments on each accepted score. It wraps to 0 after NUM_CLASS-1. The score position within the frame is `cnt`; there is no start-of-frame input.
- Running state: `best_val`, `best_idx`, `sec_val`.
- Each accepted score `d` updates the running state as follows:
  - When `cnt==0`: best_val=d, best_idx=0, sec_val=MIN. MIN is -2^(DATA_W-1) when signed, 0 when unsigned.
  - Otherwise, when `d > best_val`: sec_val=best_val, best_val=d, best_idx=cnt.
  - Otherwise, when `d > sec_val`: sec_val=d.
  - Otherwise: no change.
- All comparisons are strict, so ties keep the lower index. A score equal to best_val still updates sec_val when it is greater than sec_val; equal top scores therefore give margin 0.
- Frame completion: when a score is accepted with `cnt==NUM_CLASS-1`, the final state (including that score) is registered into `decision`, `max_out` and `margin`, and `valid_out` pulses.
- `margin` = best − second, computed in DATA_W+1 bits. With NUM_CLASS==1, second is MIN.
- Result outputs hold their value until the next frame completes.
- `clear`: resets `cnt` to 0 and discards the running state. It has priority over a `valid_in` in the same cycle, and that score is dropped. Result outputs are unaffected, and any `valid_out` pulse already scheduled still occurs.
- Gaps (`valid_in` low) may occur anywhere inside a frame and do not change state.

## Timing
- Reset values: all outputs 0, `cnt`=0, running state = MIN/0.
- Reset asserted mid-frame discards the partial frame. The next accepted score is element 0.
- Latency: `valid_out` is high in the cycle immediately after the edge that accepts the last score, with results valid in that same cycle.
- Throughput: one score per cycle, sustained across frame boundaries. Element 0 of frame k+1 may arrive in the cycle right after the last element of frame k. In that case `valid_out` for frame k is high while frame k+1 element 0 is being accepted.
- `valid_out` never stays high for two consecutive cycles unless NUM_CLASS==1 and scores are continuous. In that case it is high every cycle following an accepted score.
- Design is fully registered: no combinational path from inputs to outputs.

## Test plan
- Default parameters, signed, scores {5,-3,17,2,17,0,-100,9,16,1} continuous → one cycle after the 10th score: decision=2, max_out=17, margin=0, valid_out for exactly 1 cycle.
- Scores {-2048,-2048,...,-2047 at index 7} → decision=7, max_out=-2047, margin=1. Check signed extremes.
- SIGNED=0, scores with 12'hFFF at index 9, rest 12'h7FF → decision=9, margin=12'h800.
- Two back-to-back frames with no gap, then a frame with random valid_in gaps → three valid_out pulses, each one cycle after that frame's last score, with correct results. Outputs hold between pulses.
- Assert `clear` (with valid_in high) after the 4th score, then send a full 10-score frame → exactly one result, computed from the new frame only. Previous outputs remain stable until it arrives.
- Drop `rst_n` asynchronously mid-frame (not on a clock edge) → outputs read 0 immediately. After release, a full frame gives the correct result. Also run NUM_CLASS=1: every score yields valid_out with margin = score − MIN.

Source files
------------

// File: rtl/argmax_stream.sv
// rtl/argmax_stream.sv - streaming top-2 argmax over frames of NUM_CLASS scores
// Emits winning index, best score and best-minus-second margin one cycle after each frame.
module argmax_stream #(
  parameter int NUM_CLASS = 10,
  parameter int DATA_W    = 12,
  parameter bit SIGNED    = 1'b1,
  parameter int IDX_W     = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [IDX_W-1:0]  decision,
  output logic [DATA_W-1:0] max_out,
  output logic [DATA_W:0]   margin,
  output logic              valid_out
);

  // XOR with MIN maps signed order onto unsigned order (offset binary).
  localparam logic [DATA_W-1:0] MIN_VAL  = SIGNED ? (DATA_W'(1) << (DATA_W - 1)) : '0;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CLASS - 1);

  logic [IDX_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_best_val;
  logic [IDX_W-1:0]  r_best_idx;
  logic [DATA_W-1:0] r_sec_val;

  logic [IDX_W-1:0]  r_decision;
  logic [DATA_W-1:0] r_max_out;
  logic [DATA_W:0]   r_margin;
  logic              r_valid_out;

  logic              w_accept;
  logic              w_first;
  logic              w_last;
  logic              w_gt_best;
  logic              w_gt_sec;
  logic [DATA_W-1:0] w_d_key;
  logic [DATA_W-1:0] w_best_key;
  logic [DATA_W-1:0] w_sec_key;
  logic [DATA_W-1:0] w_nxt_best_val;
  logic [IDX_W-1:0]  w_nxt_best_idx;
  logic [DATA_W-1:0] w_nxt_sec_val;
  logic [DATA_W:0]   w_nxt_margin;

  assign w_accept   = valid_in & ~clear;
  assign w_first    = (r_cnt == '0);
  assign w_last     = (r_cnt == LAST_IDX);
  assign w_d_key    = data_in ^ MIN_VAL;
  assign w_best_key = r_best_val ^ MIN_VAL;
  assign w_sec_key  = r_sec_val ^ MIN_VAL;
  assign w_gt_best  = (w_d_key > w_best_key);
  assign w_gt_sec   = (w_d_key > w_sec_key);

  always_comb begin
    w_nxt_best_val = r_best_val;
    w_nxt_best_idx = r_best_idx;
    w_nxt_sec_val  = r_sec_val;
    if (w_first) begin
      w_nxt_best_val = data_in;
      w_nxt_best_idx = '0;
      w_nxt_sec_val  = MIN_VAL;
    end else if (w_gt_best) begin
      w_nxt_sec_val  = r_best_val;
      w_nxt_best_val = data_in;
      w_nxt_best_idx = r_cnt;
    end else if (w_gt_sec) begin
      w_nxt_sec_val  = data_in;
    end
  end

  // Offset-binary difference equals the true difference and is never negative.
  assign w_nxt_margin = {1'b0, w_nxt_best_val ^ MIN_VAL} - {1'b0, w_nxt_sec_val ^ MIN_VAL};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_best_val <= MIN_VAL;
      r_best_idx <= '0;
      r_sec_val  <= MIN_VAL;
    end else if (clear) begin
      r_cnt      <= '0;
      r_best_val <= MIN_VAL;
      r_best_idx <= '0;
      r_sec_val  <= MIN_VAL;
    end else if (valid_in) begin
      r_cnt      <= w_last ? '0 : r_cnt + IDX_W'(1);
      r_best_val <= w_nxt_best_val;
      r_best_idx <= w_nxt_best_idx;
      r_sec_val  <= w_nxt_sec_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_decision  <= '0;
      r_max_out   <= '0;
      r_margin    <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= w_accept & w_last;
      if (w_accept & w_last) begin
        r_decision <= w_nxt_best_idx;
        r_max_out  <= w_nxt_best_val;
        r_margin   <= w_nxt_margin;
      end
    end
  end

  assign decision  = r_decision;
  assign max_out   = r_max_out;
  assign margin    = r_margin;
  assign valid_out = r_valid_out;

endmodule
